// File: rtl/clk_div_sched.sv
// Runtime-programmable clock-enable divider channels.
// Divisor updates are deferred to each channel's period boundary.
module clk_div_sched #(
    parameter int NCH = 3,
    parameter int CW  = 8,
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           cfg_valid,
    output logic           cfg_ready,
    input  logic [CHW-1:0] cfg_ch,
    input  logic [CW-1:0]  cfg_div,
    output logic           cfg_err,
    input  logic           sync_req,
    output logic [NCH-1:0] div_out,
    output logic [NCH-1:0] tick,
    output logic           busy
);

    logic [NCH-1:0] pend_v;
    logic [NCH-1:0] sel;
    logic           ch_ok;
    logic           accept;

    always_comb begin
        ch_ok     = 1'b0;
        cfg_ready = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            if (cfg_ch == CHW'(i)) begin
                ch_ok     = 1'b1;
                cfg_ready = !pend_v[i];
            end
        end
    end

    assign accept = cfg_valid && cfg_ready;
    assign busy   = |pend_v;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= accept && !ch_ok;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic          en;
        logic [CW-1:0] d;
        logic [CW-1:0] cnt;
        logic [CW-1:0] pend_d;
        logic          last;

        assign sel[g] = accept && (cfg_ch == CHW'(g));
        assign last   = (cnt == d - CW'(1));

        assign tick[g]    = en && (cnt == '0);
        assign div_out[g] = en && (cnt != '0) && (cnt <= (d >> 1));

        always_ff @(posedge clk) begin
            if (!resetn) begin
                en        <= 1'b0;
                d         <= '0;
                cnt       <= '0;
                pend_v[g] <= 1'b0;
                pend_d    <= '0;
            end else if (sync_req) begin
                // Sync applies any update now, including one arriving this edge
                cnt <= '0;
                if (sel[g]) begin
                    en        <= (cfg_div > CW'(1));
                    d         <= cfg_div;
                    pend_v[g] <= 1'b0;
                end else if (pend_v[g]) begin
                    en        <= (pend_d > CW'(1));
                    d         <= pend_d;
                    pend_v[g] <= 1'b0;
                end
            end else if (sel[g] && !en) begin
                en  <= (cfg_div > CW'(1));
                d   <= cfg_div;
                cnt <= '0;
            end else begin
                if (sel[g]) begin
                    pend_v[g] <= 1'b1;
                    pend_d    <= cfg_div;
                end
                if (en) begin
                    if (last) begin
                        cnt <= '0;
                        if (pend_v[g]) begin
                            en        <= (pend_d > CW'(1));
                            d         <= pend_d;
                            pend_v[g] <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_clk_div_sched.sv
// Bench for clk_div_sched: directed scenarios plus random traffic
// checked every cycle against a period/phase model.
module tb_clk_div_sched;

    localparam int NCH = 3;
    localparam int CW  = 8;
    localparam int CHW = 2;

    logic           clk = 1'b0;
    logic           resetn = 1'b0;
    logic           cfg_valid = 1'b0;
    logic           cfg_ready;
    logic [CHW-1:0] cfg_ch = '0;
    logic [CW-1:0]  cfg_div = '0;
    logic           cfg_err;
    logic           sync_req = 1'b0;
    logic [NCH-1:0] div_out;
    logic [NCH-1:0] tick;
    logic           busy;

    clk_div_sched #(.NCH(NCH), .CW(CW)) dut (
        .clk(clk),
        .resetn(resetn),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch),
        .cfg_div(cfg_div),
        .cfg_err(cfg_err),
        .sync_req(sync_req),
        .div_out(div_out),
        .tick(tick),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: enable, period length, phase within period, queued divisor
    bit m_en[NCH];
    int m_per[NCH];
    int m_ph[NCH];
    bit m_pv[NCH];
    int m_pd[NCH];
    bit m_err;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [NCH-1:0] exp_div();
        logic [NCH-1:0] r = '0;
        for (int i = 0; i < NCH; i++)
            r[i] = m_en[i] && m_ph[i] >= 1 && m_ph[i] <= m_per[i] / 2;
        return r;
    endfunction

    function automatic logic [NCH-1:0] exp_tick();
        logic [NCH-1:0] r = '0;
        for (int i = 0; i < NCH; i++)
            r[i] = m_en[i] && m_ph[i] == 0;
        return r;
    endfunction

    function automatic logic exp_busy();
        logic r = 1'b0;
        for (int i = 0; i < NCH; i++)
            r |= m_pv[i];
        return r;
    endfunction

    function automatic void start_period(int i, int dv);
        m_en[i]  = dv >= 2;
        m_per[i] = dv;
        m_ph[i]  = 0;
        m_pv[i]  = 0;
    endfunction

    function automatic void model_edge(bit r, bit v, int ch, int dv, bit s);
        bit rd;
        bit acc;
        if (!r) begin
            for (int i = 0; i < NCH; i++) begin
                m_en[i] = 0; m_per[i] = 0; m_ph[i] = 0;
                m_pv[i] = 0; m_pd[i] = 0;
            end
            m_err = 0;
            return;
        end
        rd    = (ch >= NCH) ? 1'b1 : !m_pv[ch];
        acc   = v && rd;
        m_err = acc && ch >= NCH;
        for (int i = 0; i < NCH; i++) begin
            bit hit = acc && ch == i;
            if (s) begin
                if (hit) start_period(i, dv);
                else if (m_pv[i]) start_period(i, m_pd[i]);
                else m_ph[i] = 0;
            end else if (hit && !m_en[i]) begin
                start_period(i, dv);
            end else if (m_en[i]) begin
                bit wrap = (m_ph[i] + 1 == m_per[i]);
                bit had  = m_pv[i];
                m_ph[i] = wrap ? 0 : m_ph[i] + 1;
                if (hit) begin
                    m_pv[i] = 1;
                    m_pd[i] = dv;
                end
                if (wrap && had) start_period(i, m_pd[i]);
            end
        end
    endfunction

    task automatic step(bit r, bit v, int ch, int dv, bit s);
        bit rd;
        @(negedge clk);
        resetn    = r;
        cfg_valid = v;
        cfg_ch    = CHW'(ch);
        cfg_div   = CW'(dv);
        sync_req  = s;
        #1;
        rd = (ch >= NCH) ? 1'b1 : !m_pv[ch];
        check("div_out", div_out, exp_div());
        check("tick", tick, exp_tick());
        check("busy", busy, exp_busy());
        check("cfg_err", cfg_err, m_err);
        check("cfg_ready", cfg_ready, rd);
        model_edge(r, v, ch, dv, s);
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++) step(1, 0, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < NCH; i++) begin
            m_en[i] = 0; m_per[i] = 0; m_ph[i] = 0;
            m_pv[i] = 0; m_pd[i] = 0;
        end
        m_err = 0;

        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check("rst_div", div_out, '0);
        check("rst_tick", tick, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", cfg_ready, 1'b1);

        step(1, 1, 0, 2, 0);
        idle(5);
        step(1, 1, 1, 6, 0);
        idle(13);

        step(1, 1, 0, 4, 0);
        idle(1);
        step(1, 1, 0, 6, 0);
        for (int k = 0; k < 5; k++) step(1, 1, 0, 3, 0);
        idle(8);
        step(1, 1, 3, 5, 0);
        idle(2);
        check("err_gone", cfg_err, 1'b0);

        step(1, 1, 0, 4, 0);
        idle(4);
        step(1, 0, 0, 0, 1);
        idle(6);
        step(1, 1, 2, 9, 0);
        idle(2);
        step(1, 1, 2, 5, 1);
        idle(6);

        idle(3);
        step(0, 0, 0, 0, 0);
        idle(4);
        check("post_rst_div", div_out, '0);
        check("post_rst_busy", busy, 1'b0);
        step(1, 1, 0, 5, 0);
        step(1, 1, 1, 7, 0);
        idle(3);
        step(1, 1, 1, 1, 0);
        idle(10);

        for (int k = 0; k < 4000; k++) begin
            bit r = ($urandom_range(0, 199) != 0);
            bit v = ($urandom_range(0, 9) < 4);
            int ch = $urandom_range(0, 3);
            int sel = $urandom_range(0, 19);
            int dv;
            bit s = ($urandom_range(0, 39) == 0);
            if (sel == 0) dv = 0;
            else if (sel == 1) dv = 1;
            else if (sel == 2) dv = $urandom_range(2, 255);
            else dv = $urandom_range(2, 12);
            step(r, v, ch, dv, s);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
